// File: rtl/data_bus_access_pkg.sv
// Shared constants for data_bus_access: access-width codes, exception codes,
// FSM state encoding and the alignment rule.
package data_bus_access_pkg;

    localparam logic [1:0] MEM_WIDTH_NONE = 2'd0;
    localparam logic [1:0] MEM_WIDTH_BYTE = 2'd1;
    localparam logic [1:0] MEM_WIDTH_HALF = 2'd2;
    localparam logic [1:0] MEM_WIDTH_WORD = 2'd3;

    localparam int EXCEPTION_LEN = 3;

    localparam logic [EXCEPTION_LEN-1:0] EXCEP_NONE             = 3'd0;
    localparam logic [EXCEPTION_LEN-1:0] EXCEP_MISALIGNED_LOAD  = 3'd1;
    localparam logic [EXCEPTION_LEN-1:0] EXCEP_MISALIGNED_STORE = 3'd2;
    localparam logic [EXCEPTION_LEN-1:0] EXCEP_LOAD_FAULT       = 3'd3;
    localparam logic [EXCEPTION_LEN-1:0] EXCEP_STORE_FAULT      = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bytes are always aligned; halves need an even address; words need addr[1:0]=0.
    function automatic logic is_aligned(input logic [1:0] addr_lo, input logic [1:0] width);
        case (width)
            MEM_WIDTH_HALF: return ~addr_lo[0];
            MEM_WIDTH_WORD: return (addr_lo == 2'b00);
            default:        return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Combinational lane steering: byte enables, write-data placement and
// read-data extraction/zero-extension for a 32-bit word bus.
module byte_lane_align
    import data_bus_access_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  width,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_placed,
    output logic [31:0] rdata_extracted
);

    logic [4:0]  shamt;
    logic [31:0] mask;

    assign shamt = {offset, 3'b000};

    always_comb begin
        byte_en = 4'b0000;
        mask    = 32'h0000_0000;
        case (width)
            MEM_WIDTH_BYTE: begin
                byte_en = 4'b0001 << offset;
                mask    = 32'h0000_00FF;
            end
            MEM_WIDTH_HALF: begin
                byte_en = 4'b0011 << offset;
                mask    = 32'h0000_FFFF;
            end
            MEM_WIDTH_WORD: begin
                byte_en = 4'b1111;
                mask    = 32'hFFFF_FFFF;
            end
            default: ;
        endcase
    end

    assign wdata_placed    = wdata << shamt;
    assign rdata_extracted = (rdata >> shamt) & mask;

endmodule

// File: rtl/data_bus_access.sv
// Executor-to-bus load/store unit: IDLE -> REQ -> DONE handshake with alignment checks.
// Optional bus-wait timeout enabled by defining DATA_BUS_TIMEOUT_EN.
module data_bus_access
    import data_bus_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              addr_In,
    input  logic [31:0]              data_In,
    input  logic [1:0]               dataWidth_In,
    input  logic                     isRead_In,
    input  logic                     inputValid_In,
    output logic [31:0]              data_Out,
    output logic                     operationOK_Out,
    output logic [EXCEPTION_LEN-1:0] exception_Out,
    output logic                     busReq_Out,
    output logic [31:0]              busAddr_Out,
    output logic                     busWrite_Out,
    output logic [3:0]               busByteEn_Out,
    output logic [31:0]              busWData_Out,
    input  logic [31:0]              busRData_In,
    input  logic                     busAck_In,
    input  logic                     busErr_In
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

    state_t                   state, state_next;
    logic [31:0]              addr_q, addr_next;
    logic [31:0]              data_q, data_next;
    logic [1:0]               width_q, width_next;
    logic                     is_read_q, is_read_next;
    logic [31:0]              result_q, result_next;
    logic [EXCEPTION_LEN-1:0] exc_q, exc_next;
    logic [3:0]               lane_en;
    logic [31:0]              lane_wdata;
    logic [31:0]              lane_rdata;
    logic                     timed_out;

    byte_lane_align u_lane (
        .offset          (addr_q[1:0]),
        .width           (width_q),
        .wdata           (data_q),
        .rdata           (busRData_In),
        .byte_en         (lane_en),
        .wdata_placed    (lane_wdata),
        .rdata_extracted (lane_rdata)
    );

`ifdef DATA_BUS_TIMEOUT_EN
    logic [15:0] wait_cnt;

    // Cleared whenever not waiting, so every REQ entry starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state != ST_REQ) begin
            wait_cnt <= '0;
        end else if (!busAck_In && !busErr_In) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    assign timed_out = (state == ST_REQ) && !busAck_In &&
                       (wait_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            width_q   <= MEM_WIDTH_NONE;
            is_read_q <= 1'b0;
            result_q  <= '0;
            exc_q     <= EXCEP_NONE;
        end else begin
            state     <= state_next;
            addr_q    <= addr_next;
            data_q    <= data_next;
            width_q   <= width_next;
            is_read_q <= is_read_next;
            result_q  <= result_next;
            exc_q     <= exc_next;
        end
    end

    always_comb begin
        state_next   = state;
        addr_next    = addr_q;
        data_next    = data_q;
        width_next   = width_q;
        is_read_next = is_read_q;
        result_next  = result_q;
        exc_next     = exc_q;
        case (state)
            ST_IDLE: begin
                if (inputValid_In) begin
                    addr_next    = addr_In;
                    data_next    = data_In;
                    width_next   = dataWidth_In;
                    is_read_next = isRead_In;
                    result_next  = '0;
                    if (dataWidth_In == MEM_WIDTH_NONE) begin
                        state_next = ST_DONE;
                        exc_next   = EXCEP_NONE;
                    end else if (!is_aligned(addr_In[1:0], dataWidth_In)) begin
                        state_next = ST_DONE;
                        exc_next   = isRead_In ? EXCEP_MISALIGNED_LOAD : EXCEP_MISALIGNED_STORE;
                    end else begin
                        state_next = ST_REQ;
                        exc_next   = EXCEP_NONE;
                    end
                end
            end
            ST_REQ: begin
                // Error outranks a simultaneous ack; a timeout is reported as a fault.
                if (busErr_In || timed_out) begin
                    state_next  = ST_DONE;
                    result_next = '0;
                    exc_next    = is_read_q ? EXCEP_LOAD_FAULT : EXCEP_STORE_FAULT;
                end else if (busAck_In) begin
                    state_next  = ST_DONE;
                    result_next = is_read_q ? lane_rdata : 32'h0;
                    exc_next    = EXCEP_NONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign busReq_Out      = (state == ST_REQ);
    assign busAddr_Out     = busReq_Out ? {addr_q[31:2], 2'b00} : 32'h0;
    assign busWrite_Out    = busReq_Out & ~is_read_q;
    assign busByteEn_Out   = busReq_Out ? lane_en : 4'b0000;
    assign busWData_Out    = busReq_Out ? lane_wdata : 32'h0;

    assign operationOK_Out = (state == ST_DONE);
    assign data_Out        = operationOK_Out ? result_q : 32'h0;
    assign exception_Out   = operationOK_Out ? exc_q : EXCEP_NONE;

endmodule

// File: tb/tb_data_bus_access.sv
// Randomized and directed bench for data_bus_access with a behavioural bus responder.
module tb_data_bus_access;
    import data_bus_access_pkg::*;

    localparam int TO = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [31:0]              addr_In, data_In;
    logic [1:0]               dataWidth_In;
    logic                     isRead_In, inputValid_In;
    logic [31:0]              data_Out;
    logic                     operationOK_Out;
    logic [EXCEPTION_LEN-1:0] exception_Out;
    logic                     busReq_Out, busWrite_Out;
    logic [31:0]              busAddr_Out, busWData_Out, busRData_In;
    logic [3:0]               busByteEn_Out;
    logic                     busAck_In, busErr_In;

    int tests_run = 0;
    int tests_failed = 0;

    data_bus_access #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .addr_In(addr_In), .data_In(data_In), .dataWidth_In(dataWidth_In),
        .isRead_In(isRead_In), .inputValid_In(inputValid_In),
        .data_Out(data_Out), .operationOK_Out(operationOK_Out), .exception_Out(exception_Out),
        .busReq_Out(busReq_Out), .busAddr_Out(busAddr_Out), .busWrite_Out(busWrite_Out),
        .busByteEn_Out(busByteEn_Out), .busWData_Out(busWData_Out),
        .busRData_In(busRData_In), .busAck_In(busAck_In), .busErr_In(busErr_In)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One transaction with a bus that answers after `waits` extra REQ cycles.
    task automatic run_access(input string tag, input logic [31:0] a, input logic [31:0] d,
                              input logic [1:0] w, input logic rd, input int waits,
                              input logic [31:0] rword, input logic give_err, input logic give_ack);
        int off, nbytes, exp_lat, exp_reqc, n, left, reqc;
        logic aligned, ok_seen;
        logic [31:0] exp_data, exp_wdata, exp_mask;
        logic [3:0] exp_be;
        logic [EXCEPTION_LEN-1:0] exp_exc;

        off       = int'(a[1:0]);
        nbytes    = (w == MEM_WIDTH_BYTE) ? 1 : (w == MEM_WIDTH_HALF) ? 2 : 4;
        aligned   = (off % nbytes) == 0;
        exp_mask  = 32'((64'd1 << (8 * nbytes)) - 64'd1);
        exp_be    = 4'(((1 << nbytes) - 1) << off);
        exp_wdata = d << (8 * off);
        exp_data  = 32'h0;
        exp_exc   = EXCEP_NONE;
        if (w == MEM_WIDTH_NONE) begin
            exp_lat = 1; exp_reqc = 0;
        end else if (!aligned) begin
            exp_lat = 1; exp_reqc = 0;
            exp_exc = rd ? EXCEP_MISALIGNED_LOAD : EXCEP_MISALIGNED_STORE;
        end else if (give_err || !give_ack) begin
            exp_exc  = rd ? EXCEP_LOAD_FAULT : EXCEP_STORE_FAULT;
            exp_reqc = give_err ? waits + 1 : TO;
            exp_lat  = exp_reqc + 1;
        end else begin
            exp_reqc = waits + 1;
            exp_lat  = waits + 2;
            if (rd) exp_data = (rword >> (8 * off)) & exp_mask;
        end

        addr_In = a; data_In = d; dataWidth_In = w; isRead_In = rd; inputValid_In = 1'b1;
        @(posedge clk); #1;
        inputValid_In = 1'b0;
        addr_In = $urandom; data_In = $urandom;
        dataWidth_In = 2'($urandom); isRead_In = 1'($urandom);

        n = 0; reqc = 0; left = waits; ok_seen = 1'b0;
        while (!ok_seen && n < 40) begin
            n++;
            @(negedge clk);
            busRData_In = $urandom;
            if (busReq_Out) begin
                reqc++;
                check_val({tag, "_addr"}, busAddr_Out, {a[31:2], 2'b00});
                check_val({tag, "_be"}, 32'(busByteEn_Out), 32'(exp_be));
                check_val({tag, "_wr"}, 32'(busWrite_Out), 32'(!rd));
                check_val({tag, "_wdata"}, busWData_Out, exp_wdata);
                if (left == 0) begin
                    busAck_In = give_ack; busErr_In = give_err; busRData_In = rword;
                end else begin
                    left--;
                end
            end
            if (operationOK_Out) begin
                ok_seen = 1'b1;
                check_val({tag, "_lat"}, n, exp_lat);
                check_val({tag, "_data"}, data_Out, exp_data);
                check_val({tag, "_exc"}, 32'(exception_Out), 32'(exp_exc));
            end
            @(posedge clk); #1;
            busAck_In = 1'b0; busErr_In = 1'b0;
        end
        check_val({tag, "_done"}, 32'(ok_seen), 32'd1);
        check_val({tag, "_reqc"}, reqc, exp_reqc);
    endtask

    initial begin
        int okc;
        logic e, k;
        rst = 1'b1;
        addr_In = '0; data_In = '0; dataWidth_In = MEM_WIDTH_NONE; isRead_In = 1'b0;
        inputValid_In = 1'b0; busRData_In = '0; busAck_In = 1'b0; busErr_In = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_req", 32'(busReq_Out), 32'd0);
        check_val("rst_ok", 32'(operationOK_Out), 32'd0);
        check_val("rst_data", data_Out, 32'd0);
        check_val("rst_exc", 32'(exception_Out), 32'(EXCEP_NONE));
        check_val("rst_bus", busAddr_Out | busWData_Out | 32'(busByteEn_Out), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_access("ldw", 32'h100, 32'h0, MEM_WIDTH_WORD, 1'b1, 0, 32'hDEADBEEF, 1'b0, 1'b1);
        run_access("ldb", 32'h103, 32'h0, MEM_WIDTH_BYTE, 1'b1, 0, 32'hAABBCCDD, 1'b0, 1'b1);
        run_access("sth", 32'h202, 32'h1234, MEM_WIDTH_HALF, 1'b0, 3, 32'h5A5A5A5A, 1'b0, 1'b1);
        run_access("misw", 32'h101, 32'h0, MEM_WIDTH_WORD, 1'b1, 0, 32'h0, 1'b0, 1'b1);
        run_access("mish", 32'h3, 32'hFFFF, MEM_WIDTH_HALF, 1'b0, 0, 32'h0, 1'b0, 1'b1);
        run_access("none", 32'h7, 32'h99, MEM_WIDTH_NONE, 1'b1, 0, 32'h0, 1'b0, 1'b1);
        run_access("errst", 32'h10, 32'h55, MEM_WIDTH_WORD, 1'b0, 1, 32'h0, 1'b1, 1'b1);
        run_access("errld", 32'h22, 32'h0, MEM_WIDTH_HALF, 1'b1, 2, 32'h12345678, 1'b1, 1'b0);

        // Valid held through DONE: next acceptance only in the following IDLE cycle.
        addr_In = 32'h101; dataWidth_In = MEM_WIDTH_WORD; isRead_In = 1'b1; inputValid_In = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); check_val("hold_ok1", 32'(operationOK_Out), 32'd1);
        @(posedge clk); #1;
        @(negedge clk); check_val("hold_idle", 32'(operationOK_Out), 32'd0);
        @(posedge clk); #1;
        @(negedge clk); check_val("hold_ok2", 32'(operationOK_Out), 32'd1);
        inputValid_In = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of REQ abandons the transfer.
        addr_In = 32'h100; dataWidth_In = MEM_WIDTH_WORD; isRead_In = 1'b1; inputValid_In = 1'b1;
        @(posedge clk); #1;
        inputValid_In = 1'b0;
        @(negedge clk); check_val("rreq_on", 32'(busReq_Out), 32'd1);
        #2 rst = 1'b1;
        #1 check_val("rreq_off", 32'(busReq_Out), 32'd0);
        check_val("rreq_addr", busAddr_Out, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; busAck_In = 1'b1;
        okc = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (operationOK_Out) okc++;
            @(posedge clk); #1;
            busAck_In = 1'b0;
        end
        check_val("rreq_nook", okc, 32'd0);

`ifdef DATA_BUS_TIMEOUT_EN
        run_access("tmo", 32'h40, 32'h0, MEM_WIDTH_WORD, 1'b1, 100, 32'h0, 1'b0, 1'b0);
`endif

        for (int i = 0; i < 60; i++) begin
            e = ($urandom_range(0, 5) == 0);
            k = e ? 1'($urandom) : 1'b1;
            run_access("rnd", $urandom, $urandom, 2'($urandom), 1'($urandom),
                       $urandom_range(0, 3), $urandom, e, k);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/data_bus_access.md
DATA_BUS_ACCESS -- requirements
Module: data_bus_access

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, asynchronous active-high reset.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, is the bus-wait limit in cycles; it is used only with DATA_BUS_TIMEOUT_EN.
REQ-003 Executor-side ports:
- addr_In input 32, byte address.
- data_In input 32, store data, right-aligned.
- dataWidth_In input 2, MEM_WIDTH_NONE/BYTE/HALF/WORD.
- isRead_In input 1, 1 = load, 0 = store.
- inputValid_In input 1, request valid.
REQ-004 Executor-side results:
- data_Out output 32, load data, right-aligned and zero-extended.
- operationOK_Out output 1, one-cycle completion pulse.
- exception_Out output EXCEPTION_LEN, completion status.
REQ-005 Bus-side outputs:
- busReq_Out output 1, request.
- busAddr_Out output 32, word-aligned address.
- busWrite_Out output 1, write.
- busByteEn_Out output 4, byte lanes.
- busWData_Out output 32, lane-placed write data.
REQ-006 Bus-side inputs: busRData_In input 32, read word; busAck_In input 1, transfer done; busErr_In input 1, bus error.

Function
REQ-007 The FSM SHALL have states IDLE, REQ and DONE.
REQ-008 IDLE with inputValid_In=1 SHALL latch addr, data, width and isRead.
- Aligned access with width != NONE: go to REQ.
- Otherwise: go to DONE.
REQ-009 Alignment rules: HALF requires addr[0]=0; WORD requires addr[1:0]=0; BYTE is always aligned.
REQ-010 A misaligned access SHALL NOT assert busReq_Out. Its status is EXCEP_MISALIGNED_LOAD or EXCEP_MISALIGNED_STORE, according to isRead.
REQ-011 Width NONE SHALL complete with EXCEP_NONE, data_Out=0 and no bus cycle.
REQ-012 In REQ, busReq_Out=1 and the bus fields are stable:
- busAddr_Out = {addr[31:2],2'b00}.
- busByteEn_Out: BYTE = 4'b0001<<addr[1:0]; HALF = 4'b0011<<addr[1:0]; WORD = 4'b1111.
- busWData_Out = data shifted left by 8*addr[1:0].
REQ-013 REQ SHALL stay REQ until busAck_In or busErr_In is sampled high at a clock edge, then go to DONE.
- If both are high, busErr_In takes priority.
REQ-014 On busAck_In with a load, the module SHALL register data = busRData_In>>(8*addr[1:0]), masked to width and zero-extended.
REQ-015 On busErr_In the status SHALL be EXCEP_LOAD_FAULT or EXCEP_STORE_FAULT; data_Out SHALL be 0.
REQ-016 DONE SHALL last exactly one cycle.
- operationOK_Out=1, with data_Out and exception_Out valid.
- DONE always goes to IDLE.
REQ-017 Outside DONE: operationOK_Out=0, data_Out=0, exception_Out=EXCEP_NONE, busReq_Out=0.
REQ-018 Latency from IDLE acceptance edge to the OK cycle:
- Non-bus completion: 1 cycle.
- Bus completion: 2 cycles plus bus wait states.
REQ-019 Once latched, a request SHALL complete even if inputValid_In falls; input changes during REQ SHALL be ignored.
REQ-020 inputValid_In held high during DONE SHALL NOT start a new request until the following IDLE cycle.
REQ-021 Store data_Out SHALL be 0.

Reset
REQ-022 rst=1 SHALL immediately force IDLE and clear every output and latched field to 0, with exception_Out=EXCEP_NONE.
REQ-023 Reset asserted in REQ SHALL drop busReq_Out asynchronously, abandon the transaction and emit no OK pulse.

Configuration
REQ-024 Macro DATA_BUS_TIMEOUT_EN, when defined, SHALL add an 8..16-bit wait counter.
- The counter clears on entry to REQ and increments each REQ cycle without ack or err.
- At TIMEOUT_CYCLES, the module goes to DONE with the load/store fault exception and drops busReq_Out.
REQ-025 Without DATA_BUS_TIMEOUT_EN there SHALL be no counter, and REQ waits indefinitely.

Structure
REQ-026 The shared constants file SHALL hold:
- MEM_WIDTH_* codes.
- EXCEPTION_LEN.
- EXCEP_NONE, EXCEP_MISALIGNED_LOAD, EXCEP_MISALIGNED_STORE, EXCEP_LOAD_FAULT, EXCEP_STORE_FAULT.
- The FSM state encodings.
REQ-027 Lane logic SHALL be one combinational sub-module, byte_lane_align: byte-enable generation, write-data shift and read-data extract/mask. The FSM stays in data_bus_access.

Verification
REQ-028 Load word: addr 0x100, WORD, bus acks on the first REQ cycle with 0xDEADBEEF -> OK 2 cycles after acceptance, data_Out 0xDEADBEEF, EXCEP_NONE, byteEn 4'b1111.
REQ-029 Byte load: addr 0x103, BYTE, rdata 0xAABBCCDD -> busAddr 0x100, byteEn 4'b1000, data_Out 0x000000AA.
REQ-030 Store half: addr 0x202, data 0x1234, 3 wait states -> busWData 0x12340000, byteEn 4'b1100, OK on cycle 5, data_Out 0.
REQ-031 Misaligned: WORD load at 0x101 -> no busReq, OK after 1 cycle, EXCEP_MISALIGNED_LOAD; HALF store at 0x3 -> EXCEP_MISALIGNED_STORE.
REQ-032 Error and reset: busErr_In with busAck_In on a store -> EXCEP_STORE_FAULT; rst pulse mid-REQ -> busReq 0 immediately and no OK.
REQ-033 With DATA_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=4, bus never acks a load -> EXCEP_LOAD_FAULT after 4 REQ cycles.
